// File: rtl/seq_mem_loader.sv
// Packs a streamed base sequence into the flat base memory read by the k-mer extender.
// Optional SEQ_LOADER_BASE_CHECK_EN: replaces illegal base codes with N and counts them.
module seq_mem_loader #(
  parameter int unsigned BASE_LEN  = 4,
  parameter int unsigned MEM_BASES = 64,
  parameter int unsigned MEM_LEN   = MEM_BASES * BASE_LEN,
  parameter int unsigned BPB       = 2,
  parameter int unsigned CNT_W     = $clog2(BPB + 1),
  parameter int unsigned LEN_W     = $clog2(MEM_BASES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BPB*BASE_LEN-1:0] in_bases,
  input  logic [CNT_W-1:0]        in_count,
  input  logic                    in_last,
  output logic [MEM_LEN-1:0]      mem_out,
  output logic                    mem_valid,
  output logic [LEN_W-1:0]        seq_len,
  output logic                    overflow,
  input  logic                    mem_release
`ifdef SEQ_LOADER_BASE_CHECK_EN
  ,
  output logic [7:0]              bad_base_cnt
`endif
);

  localparam int unsigned PTR_W = LEN_W + 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [MEM_LEN-1:0]      mem_q, mem_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q;
  logic                    valid_q;
  logic                    hs_c;
  logic [CNT_W-1:0]        n_c;
  logic [BPB*BASE_LEN-1:0] codes_c;
  logic [PTR_W-1:0]        pos_c [BPB];
  logic [SUM_W-1:0]        sum_c;

  assign hs_c = in_valid && ready_q;
  assign n_c  = (in_count > CNT_W'(BPB)) ? CNT_W'(BPB) : in_count;

`ifdef SEQ_LOADER_BASE_CHECK_EN
  logic [7:0]       bad_q, bad_d;
  logic [CNT_W-1:0] nbad_c;
  logic [8:0]       bad_sum_c;

  function automatic logic legal_code(input logic [BASE_LEN-1:0] code);
    return (code == '0) || $onehot(code);
  endfunction
`endif

  // Base codes as they will be stored (sanitised when checking is enabled)
  always_comb begin
    codes_c = in_bases;
`ifdef SEQ_LOADER_BASE_CHECK_EN
    nbad_c = '0;
    for (int k = 0; k < int'(BPB); k++) begin
      if ((CNT_W'(k) < n_c) && !legal_code(in_bases[k*BASE_LEN +: BASE_LEN])) begin
        codes_c[k*BASE_LEN +: BASE_LEN] = '0;
        nbad_c = nbad_c + CNT_W'(1);
      end
    end
`endif
  end

  // Next-state, memory write and pointer logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    ovf_d   = ovf_q;
    sum_c   = SUM_W'(ptr_q) + SUM_W'(n_c);
    for (int k = 0; k < int'(BPB); k++) begin
      pos_c[k] = ptr_q + PTR_W'(k);
    end

    unique case (state_q)
      S_LOAD: begin
        if (hs_c) begin
          for (int i = 0; i < int'(MEM_BASES); i++) begin
            for (int k = 0; k < int'(BPB); k++) begin
              if ((CNT_W'(k) < n_c) && (pos_c[k] == PTR_W'(i))) begin
                mem_d[i*BASE_LEN +: BASE_LEN] = codes_c[k*BASE_LEN +: BASE_LEN];
              end
            end
          end
          for (int k = 0; k < int'(BPB); k++) begin
            if ((CNT_W'(k) < n_c) && (pos_c[k] >= PTR_W'(MEM_BASES))) begin
              ovf_d = 1'b1;
            end
          end
          ptr_d = (sum_c > SUM_W'(MEM_BASES)) ? PTR_W'(MEM_BASES) : PTR_W'(sum_c);
          if (in_last) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (mem_release) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          mem_d   = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

`ifdef SEQ_LOADER_BASE_CHECK_EN
  // Saturating count of replaced codes, cleared together with the memory
  always_comb begin
    bad_d     = bad_q;
    bad_sum_c = {1'b0, bad_q} + 9'(nbad_c);
    if ((state_q == S_LOAD) && hs_c) begin
      bad_d = (bad_sum_c > 9'd255) ? 8'hFF : bad_sum_c[7:0];
    end else if ((state_q == S_HOLD) && mem_release) begin
      bad_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= '0;
    end else begin
      bad_q <= bad_d;
    end
  end

  assign bad_base_cnt = bad_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      mem_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == S_LOAD);
      valid_q <= (state_d == S_HOLD);
    end
  end

  assign in_ready  = ready_q;
  assign mem_valid = valid_q;
  assign mem_out   = mem_q;
  assign overflow  = ovf_q;
  assign seq_len   = LEN_W'(ptr_q);

endmodule

// File: tb/tb_seq_mem_loader.sv
// Self-checking bench for seq_mem_loader (MEM_BASES=8, BPB=2): vector table,
// hand sequences and randomized beats against a positional reference model.
module tb_seq_mem_loader;

  localparam int unsigned BL  = 4;
  localparam int unsigned MB  = 8;
  localparam int unsigned ML  = MB * BL;
  localparam int unsigned BPB = 2;
  localparam int unsigned CW  = 2;
  localparam int unsigned LW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_bases;
  logic [CW-1:0] in_count;
  logic          in_last;
  logic [ML-1:0] mem_out;
  logic          mem_valid;
  logic [LW-1:0] seq_len;
  logic          overflow;
  logic          mem_release;
`ifdef SEQ_LOADER_BASE_CHECK_EN
  logic [7:0]    bad_base_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_mem_loader #(
    .BASE_LEN (BL),
    .MEM_BASES(MB),
    .MEM_LEN  (ML),
    .BPB      (BPB),
    .CNT_W    (CW),
    .LEN_W    (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bases   (in_bases),
    .in_count   (in_count),
    .in_last    (in_last),
    .mem_out    (mem_out),
    .mem_valid  (mem_valid),
    .seq_len    (seq_len),
    .overflow   (overflow),
    .mem_release(mem_release)
`ifdef SEQ_LOADER_BASE_CHECK_EN
    ,
    .bad_base_cnt(bad_base_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [7:0]  bases;
    logic [1:0]  cnt;
    logic        last;
    logic        rel;
    logic [31:0] mem;
    logic [3:0]  len;
    logic        ovf;
    logic        mv;
    logic        rdy;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic v, input logic [7:0] b, input logic [1:0] c,
                              input logic l, input logic r, input logic [31:0] m,
                              input logic [3:0] n, input logic o, input logic mv,
                              input logic rd);
    vec_t t;
    t.valid = v; t.bases = b; t.cnt = c; t.last = l; t.rel = r;
    t.mem = m; t.len = n; t.ovf = o; t.mv = mv; t.rdy = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] m, input logic [3:0] n,
                           input logic o, input logic mv, input logic rd,
                           input logic [7:0] bad);
    chk({tag, "_mem"}, mem_out, m);
    chk({tag, "_len"}, 32'(seq_len), 32'(n));
    chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    chk({tag, "_mvalid"}, 32'(mem_valid), 32'(mv));
    chk({tag, "_ready"}, 32'(in_ready), 32'(rd));
`ifdef SEQ_LOADER_BASE_CHECK_EN
    chk({tag, "_bad"}, 32'(bad_base_cnt), 32'(bad));
`else
    if (bad != 8'd0) $display("note: bad count expectation ignored for %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [1:0] c,
                       input logic l, input logic r);
    in_valid = v; in_bases = b; in_count = c; in_last = l; mem_release = r;
  endtask

  // Reference model: an array of stored bases plus length, overflow and hold flags
  logic [3:0] m_mem [MB];
  int         m_len;
  logic       m_ovf;
  logic       m_hold;
  int         m_bad;

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < int'(MB); i++) w[i*4 +: 4] = m_mem[i];
    return w;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < int'(MB); i++) m_mem[i] = 4'h0;
    m_len = 0; m_ovf = 1'b0; m_hold = 1'b0; m_bad = 0;
  endtask

  task automatic m_apply();
    int n;
    logic [3:0] code;
    if (m_hold) begin
      if (mem_release) m_clear();
    end else if (in_valid) begin
      n = (int'(in_count) > int'(BPB)) ? int'(BPB) : int'(in_count);
      for (int k = 0; k < n; k++) begin
        code = (k == 0) ? in_bases[3:0] : in_bases[7:4];
`ifdef SEQ_LOADER_BASE_CHECK_EN
        if (!(code inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8})) begin
          code  = 4'h0;
          m_bad = (m_bad == 255) ? 255 : m_bad + 1;
        end
`endif
        if (m_len + k < int'(MB)) m_mem[m_len + k] = code;
        else m_ovf = 1'b1;
      end
      m_len = (m_len + n > int'(MB)) ? int'(MB) : m_len + n;
      if (in_last) m_hold = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 8'h21, 2, 0, 0, 32'h21,       2, 0, 0, 1);
    tbl[1]  = mk(1, 8'h84, 2, 1, 0, 32'h8421,     4, 0, 1, 0);
    tbl[2]  = mk(1, 8'h55, 2, 0, 0, 32'h8421,     4, 0, 1, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 0, 1);
    tbl[4]  = mk(1, 8'h21, 2, 0, 0, 32'h21,       2, 0, 0, 1);
    tbl[5]  = mk(1, 8'hF4, 1, 1, 0, 32'h421,      3, 0, 1, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 0, 1);
    tbl[7]  = mk(1, 8'h21, 2, 0, 0, 32'h21,       2, 0, 0, 1);
    tbl[8]  = mk(1, 8'h84, 2, 0, 0, 32'h8421,     4, 0, 0, 1);
    tbl[9]  = mk(1, 8'h12, 2, 0, 1, 32'h128421,   6, 0, 0, 1);
    tbl[10] = mk(1, 8'h48, 2, 0, 0, 32'h48128421, 8, 0, 0, 1);
    tbl[11] = mk(1, 8'h11, 2, 1, 0, 32'h48128421, 8, 1, 1, 0);
    tbl[12] = mk(1, 8'h11, 2, 0, 1, 32'h0,        0, 0, 0, 1);
    tbl[13] = mk(1, 8'h00, 0, 1, 0, 32'h0,        0, 0, 1, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 0, 1);
    tbl[15] = mk(1, 8'h21, 3, 0, 0, 32'h21,       2, 0, 0, 1);
    tbl[16] = mk(1, 8'h00, 0, 0, 0, 32'h21,       2, 0, 0, 1);
    tbl[17] = mk(0, 8'h84, 2, 1, 0, 32'h21,       2, 0, 0, 1);
    tbl[18] = mk(1, 8'h84, 2, 1, 0, 32'h8421,     4, 0, 1, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 0, 1);

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    #7;
    check_all("reset", 32'h0, 0, 0, 0, 1, 8'd0);
    #5 rst_n = 1'b1;
    step();

    // Asynchronous reset mid-cycle discards a partial sequence
    drive(1, 8'h21, 2, 0, 0);
    step();
    drive(0, 8'h00, 0, 0, 0);
    check_all("pre_rst", 32'h21, 2, 0, 0, 1, 8'd0);
    #3 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 0, 0, 0, 1, 8'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].valid, tbl[i].bases, tbl[i].cnt, tbl[i].last, tbl[i].rel);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].mem, tbl[i].len, tbl[i].ovf,
                tbl[i].mv, tbl[i].rdy, 8'd0);
    end

    // Illegal codes: replaced and counted when checking is built in, stored otherwise
    drive(1, 8'h3F, 2, 1, 0);
    step();
`ifdef SEQ_LOADER_BASE_CHECK_EN
    check_all("bad_code", 32'h0, 2, 0, 1, 0, 8'd2);
`else
    check_all("bad_code", 32'h3F, 2, 0, 1, 0, 8'd0);
`endif
    drive(0, 8'h00, 0, 0, 1);
    step();
    check_all("bad_rel", 32'h0, 0, 0, 0, 1, 8'd0);

    m_clear();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      m_apply();
      step();
      check_all($sformatf("rnd%0d", i), m_word(), 4'(m_len), m_ovf, m_hold, !m_hold,
                8'(m_bad));
    end

    drive(0, 8'h00, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
